// File: rtl/seg7_gen_display_pkg.sv
// Shared widths, segment codes and conversion FSM states for the
// generation-count 7-segment display.
package seg7_gen_display_pkg;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int BCD_W  = 16;

  // Active-low segment patterns, bit order g..a
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } conv_state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_gen_display_if.sv
// Processor-facing strobe/clear inputs and the display/count outputs of
// the generation display, plus the conversion FSM state for debug.
interface seg7_gen_display_if;
  import seg7_gen_display_pkg::*;

  // inc_seg7 is a level: every 0->1 transition is one increment request.
  // clear is a one-cycle synchronous request. There is no ready: the block
  // accepts every request in the cycle it is presented.
  logic             inc_seg7;
  logic             clear;
  logic [BIN_W-1:0] count;
  logic             busy;
  logic [7:0]       AN;
  logic [6:0]       SEGCTRL;
  conv_state_t      dbg_state;

  modport master (
    output inc_seg7, clear,
    input  count, busy, AN, SEGCTRL, dbg_state
  );

  modport slave (
    input  inc_seg7, clear,
    output count, busy, AN, SEGCTRL, dbg_state
  );

endinterface

// File: rtl/seg7_gen_display_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock, BIN_W steps
// per conversion. start reloads the engine even while busy.
module seg7_gen_display_bin2bcd_seq
  import seg7_gen_display_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  localparam int SR_W   = BCD_W + BIN_W;
  localparam int ITER_W = $clog2(BIN_W + 1);

  logic [SR_W-1:0]   sr_q, sr_d, sr_adj;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              busy_q, busy_d;

  always_comb begin
    sr_adj = sr_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (sr_q[BIN_W+4*k +: 4] >= 4'd5)
        sr_adj[BIN_W+4*k +: 4] = sr_q[BIN_W+4*k +: 4] + 4'd3;
    end

    sr_d   = sr_q;
    iter_d = iter_q;
    busy_d = busy_q;
    if (start_i) begin
      sr_d   = {{BCD_W{1'b0}}, bin_i};
      iter_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      sr_d   = sr_adj << 1;
      iter_d = iter_q + 1'b1;
      if (iter_q == ITER_W'(BIN_W - 1))
        busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      iter_q <= iter_d;
      busy_q <= busy_d;
    end
  end

  // done marks the cycle whose clock edge applies the final step
  assign done_o = busy_q && (iter_q == ITER_W'(BIN_W - 1));
  assign busy_o = busy_q;
  assign bcd_o  = sr_q[SR_W-1 -: BCD_W];

endmodule

// File: rtl/seg7_gen_display.sv
// Generation counter fed by the processor's inc_seg7 strobe, BCD conversion
// control, and a four-digit multiplexed 7-segment driver with zero blanking.
module seg7_gen_display
  import seg7_gen_display_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int MAX_COUNT = 9999
) (
  input  logic                clock_100,
  input  logic                reset,
  seg7_gen_display_if.slave   bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);

  logic             inc_q;
  logic             inc_edge;
  logic [BIN_W-1:0] count_q, count_d;
  logic             chg_q, chg_d;

  conv_state_t      state_q;
  logic             pending_q;
  logic             busy_q;

  logic             conv_start, conv_busy, conv_done;
  logic [BCD_W-1:0] conv_bcd;

  logic [BCD_W-1:0] digits_q, digits_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  assign inc_edge = bus.inc_seg7 & ~inc_q;
  assign chg_d    = bus.clear | inc_edge;

  // clear wins over a coincident edge; the edge is simply dropped
  always_comb begin
    count_d = count_q;
    if (bus.clear)
      count_d = '0;
    else if (inc_edge)
      count_d = (count_q == BIN_W'(MAX_COUNT)) ? '0 : count_q + 1'b1;
  end

  // chg_q is seen in LATCH too, so a change landing there still reconverts
  assign conv_start = ((state_q == ST_IDLE)  && chg_q) ||
                      ((state_q == ST_LATCH) && (pending_q || chg_q));

  seg7_gen_display_bin2bcd_seq u_bin2bcd (
    .clk     (clock_100),
    .rst_n   (reset),
    .start_i (conv_start),
    .bin_i   (count_q),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (chg_q) begin
            state_q <= ST_SHIFT;
            busy_q  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (chg_q)
            pending_q <= 1'b1;
          if (conv_done || !conv_busy)
            state_q <= ST_LATCH;
        end
        ST_LATCH: begin
          if (pending_q || chg_q) begin
            state_q   <= ST_SHIFT;
            pending_q <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          pending_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign digits_d = (state_q == ST_LATCH) ? conv_bcd : digits_q;

  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = idx_q + 1'b1;
    end
  end

  // Encode from next-state digits and index so AN/SEGCTRL stay aligned
  always_comb begin
    an_d        = 8'hFF;
    an_d[idx_d] = 1'b0;
    seg_d       = seg_encode(digits_d[4*idx_d +: 4]);
    if ((idx_d != '0) && ((digits_d >> {idx_d, 2'b00}) == '0))
      seg_d = BLANK;
  end

  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) begin
      inc_q    <= 1'b0;
      count_q  <= '0;
      chg_q    <= 1'b0;
      digits_q <= '0;
      div_q    <= '0;
      idx_q    <= '0;
      an_q     <= 8'hFE;
      seg_q    <= SEG_0;
    end else begin
      inc_q    <= bus.inc_seg7;
      count_q  <= count_d;
      chg_q    <= chg_d;
      digits_q <= digits_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.busy      = busy_q;
  assign bus.AN        = an_q;
  assign bus.SEGCTRL   = seg_q;
  assign bus.dbg_state = state_q;

endmodule

// File: doc/seg7_gen_display.md
Name: seg7_gen_display

Overview:
- Downstream consumer of the processor's `inc_seg7` strobe; replaces the ad-hoc edge-clocked generation counter and the 7-segment driver feeding AN/SEGCTRL.
- Keeps a wrapping decimal generation count and converts it to BCD with a sequential double-dabble engine.
- Time-multiplexes four active-low digits on the board's 8-anode display, entirely in the `clock_100` domain.

Parameters:
- SCAN_DIV, 100000, `clock_100` cycles each digit stays lit (1 kHz digit rate at 100 MHz).
- MAX_COUNT, 9999, largest displayed count; the next increment wraps to 0.

Ports:
- clock_100  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- inc_seg7  in  1  level from the processor; each 0->1 transition increments the count once.
- clear  in  1  synchronous clear of the count; takes priority over an increment in the same cycle.
- count  out  14  current binary generation count.
- busy  out  1  high while a BCD conversion is in progress.
- AN  out  8  anode enables, active-low.
- SEGCTRL  out  7  segment drive, active-low; bit0=a … bit6=g.

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0, busy=0, digit regs=0, scan index=0, divider=0.
  - AN=8'hFE, SEGCTRL=7'b1000000 (shows "0").
  - All outputs are registered.
- Edge detect:
  - inc_q <= inc_seg7 every cycle; edge = inc_seg7 & ~inc_q.
  - inc_q resets to 0, so inc_seg7 held high across reset release counts once.
- Counter:
  - On edge: count <= (count==MAX_COUNT) ? 0 : count+1.
  - On clear: count <= 0. If clear and edge coincide, count goes to 0 and the edge is dropped.
- Conversion FSM states: IDLE, SHIFT, LATCH.
  - IDLE -> SHIFT the cycle after count changes (increment or clear). Load shift reg {16'b0, count}; iter=0; busy=1.
  - SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift left 1. iter++. After 14 iterations -> LATCH.
  - LATCH: copy the 4 BCD nibbles to the display digit regs. If pending=1, clear pending and go to SHIFT with the current count; else go to IDLE with busy=0.
  - Latency: edge at cycle N -> count valid at N+1 -> digits valid at N+17.
  - A count change while SHIFT or LATCH is active sets pending; the in-flight conversion completes unchanged.
  - Display digits change only in LATCH, so no torn values are ever shown.
- Scanner:
  - Divider counts 0..SCAN_DIV-1. On wrap, scan index advances 0->1->2->3->0.
  - AN[3:0] is the active-low one-hot of the index; AN[7:4] are always 1.
  - AN and SEGCTRL update in the same cycle.
- Leading-zero blanking:
  - Digit k (k>0) is blanked (SEGCTRL=7'h7F) when it and every higher digit are 0.
  - Digit 0 is never blanked.
- Segment encoding (active-low, g..a), 0–9:
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Any value above 9 drives 7'h7F.
- Reset mid-conversion aborts the conversion and returns every register to its reset value.

Decomposition:
- seg7_pkg:
  - 10-entry segment encoding constants and the BLANK constant (7'h7F).
  - DIGITS=4, BIN_W=14, BCD_W=16.
  - FSM state enum.
- Sub-module bin2bcd_seq:
  - Ports: start, bin[13:0], busy, done, bcd[15:0].
  - Contains the SHIFT iteration engine.
  - The top level owns the counter, pending flag, scanner, blanking and encoding.

Test Plan (SCAN_DIV=4 in the bench):
- Reset release, no stimulus -> count=0, AN=FE, SEGCTRL=40; AN rotates FE,FD,FB,F7 every 4 clocks; digits 1–3 drive 7F.
- Pulse inc_seg7 high 1 cycle, then hold high 20 cycles -> count=1 then stays 1 (single edge); busy high cycles 2–16; digit0 drives 79 from cycle 17.
- Force 1234 increments -> digits 4,3,2,1; SEGCTRL sequence 19,30,24,79 as AN cycles FE,FD,FB,F7.
- Count at 9999, one edge -> count=0; after conversion digit0 shows 40 and digits 1–3 are blanked.
- Second edge 5 cycles after the first (mid-SHIFT) -> first LATCH shows 1, second conversion starts immediately, final display 2; busy stays high continuously.
- clear and edge in the same cycle at count=57 -> count=0, display "0"; separately, reset asserted mid-SHIFT -> all outputs at reset values immediately, asynchronously.
